// File: rtl/ysyx_23060236_ifu_pf_if.sv
// Bundle of IFU fetch-side signals: AXI read channel, icache lookup/refill
// ports, backend redirect and the instruction-queue output to the decoder.
interface ysyx_23060236_ifu_pf_if #(
    parameter int unsigned ICACHE_AW = 25
);
    logic [31:0]          ifu_araddr;
    logic                 ifu_arvalid;
    logic                 ifu_arready;
    logic [1:0]           ifu_arburst;
    logic [3:0]           ifu_arlen;
    logic [31:0]          ifu_rdata;
    logic [1:0]           ifu_rresp;
    logic                 ifu_rvalid;
    logic                 ifu_rready;
    logic                 ifu_rlast;
    logic [ICACHE_AW-1:0] icache_araddr;
    logic [31:0]          icache_rdata;
    logic                 icache_hit;
    logic [ICACHE_AW-1:0] icache_awaddr;
    logic [31:0]          icache_wdata;
    logic                 icache_wvalid;
    logic                 redirect_valid;
    logic [31:0]          redirect_addr;
    logic                 idu_valid;
    logic                 idu_ready;
    logic [31:0]          idu_inst;
    logic [31:0]          idu_pc;
    logic                 idu_err;

    modport master (
        output ifu_araddr, ifu_arvalid, ifu_arburst, ifu_arlen, ifu_rready,
               icache_araddr, icache_awaddr, icache_wdata, icache_wvalid,
               idu_valid, idu_inst, idu_pc, idu_err,
        input  ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid, ifu_rlast,
               icache_rdata, icache_hit, redirect_valid, redirect_addr, idu_ready
    );

    modport slave (
        input  ifu_araddr, ifu_arvalid, ifu_arburst, ifu_arlen, ifu_rready,
               icache_araddr, icache_awaddr, icache_wdata, icache_wvalid,
               idu_valid, idu_inst, idu_pc, idu_err,
        output ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid, ifu_rlast,
               icache_rdata, icache_hit, redirect_valid, redirect_addr, idu_ready
    );
endinterface

// File: rtl/ysyx_23060236_ifu_pf.sv
// Instruction prefetch unit: looks up the icache, refills whole lines over an
// AXI INCR burst on a miss, and queues fetched instructions for the decoder.
module ysyx_23060236_ifu_pf #(
    parameter logic [31:0] ENTRY_ADDR = 32'h3000_0000,
    parameter int unsigned BLK_WORDS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ICACHE_AW  = 25
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    ysyx_23060236_ifu_pf_if.master        bus_io
);
    localparam int unsigned BW  = $clog2(BLK_WORDS);
    localparam int unsigned Off = BW + 2;
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {StReq, StChk, StAr, StR, StHalt} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   araddr_q, araddr_d;   // line base latched at miss, stable through burst
    logic [BW-1:0] beat_q, beat_d;
    logic          err_q, err_d;         // sticky burst error
    logic          drop_q, drop_d;       // burst outlived a redirect, discard its outcome
    logic          done_q, done_d;       // error burst finished, waiting for queue space

    logic [CW-1:0] count_q;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]   mem_pc_q   [FIFO_DEPTH];
    logic [31:0]   mem_inst_q [FIFO_DEPTH];
    logic          mem_err_q  [FIFO_DEPTH];

    logic          full, pop, push, push_err, wvalid, beat_bad;
    logic [31:0]   push_inst;

    assign full = (count_q == CW'(FIFO_DEPTH));
    assign pop  = (count_q != '0) && bus_io.idu_ready;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Next-state logic for the fetch FSM; redirect overrides everything at the end
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        araddr_d   = araddr_q;
        beat_d     = beat_q;
        err_d      = err_q;
        drop_d     = drop_q;
        done_d     = done_q;
        push       = 1'b0;
        push_err   = 1'b0;
        push_inst  = 32'h0;
        wvalid     = 1'b0;
        beat_bad   = 1'b0;
        unique case (state_q)
            StReq: state_d = StChk;
            StChk: begin
                if (bus_io.icache_hit) begin
                    if (!full) begin
                        push       = 1'b1;
                        push_inst  = bus_io.icache_rdata;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                    state_d = StReq;
                end else begin
                    araddr_d = {fetch_pc_q[31:Off], {Off{1'b0}}};
                    state_d  = StAr;
                end
            end
            StAr: begin
                if (bus_io.ifu_arready) state_d = StR;
            end
            StR: begin
                if (done_q) begin
                    if (drop_q) begin
                        state_d = StReq;
                    end else if (!full) begin
                        push     = 1'b1;
                        push_err = 1'b1;
                        state_d  = StHalt;
                    end
                end else if (bus_io.ifu_rvalid) begin
                    beat_bad = (bus_io.ifu_rresp != 2'b00);
                    wvalid   = !beat_bad;
                    err_d    = err_q | beat_bad;
                    beat_d   = bus_io.ifu_rlast ? '0 : beat_q + BW'(1);
                    if (bus_io.ifu_rlast) begin
                        if (drop_q || !(err_q || beat_bad)) begin
                            state_d = StReq;
                        end else if (!full) begin
                            push     = 1'b1;
                            push_err = 1'b1;
                            state_d  = StHalt;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                if (state_d != StR) begin
                    err_d  = 1'b0;
                    drop_d = 1'b0;
                    done_d = 1'b0;
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StReq;
        endcase

        if (bus_io.redirect_valid) begin
            fetch_pc_d = bus_io.redirect_addr & ~32'h3;
            push       = 1'b0;
            // A live burst must still drain on the bus; anything else restarts now
            if (state_q == StAr || (state_q == StR && state_d == StR && !done_q)) begin
                drop_d = 1'b1;
            end else begin
                state_d = StReq;
                err_d   = 1'b0;
                drop_d  = 1'b0;
                done_d  = 1'b0;
            end
        end
    end

    // FSM and fetch-control registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StReq;
            fetch_pc_q <= ENTRY_ADDR;
            araddr_q   <= {ENTRY_ADDR[31:Off], {Off{1'b0}}};
            beat_q     <= '0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            araddr_q   <= araddr_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
            done_q     <= done_d;
        end
    end

    // Queue occupancy and pointers; redirect flushes regardless of push/pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else if (bus_io.redirect_valid) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Queue storage; validity is tracked by count_q so no reset is needed
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
            mem_inst_q[wr_ptr_q] <= push_inst;
            mem_err_q[wr_ptr_q]  <= push_err;
        end
    end

    assign bus_io.ifu_araddr    = araddr_q;
    assign bus_io.ifu_arvalid   = (state_q == StAr);
    assign bus_io.ifu_arburst   = 2'b01;
    assign bus_io.ifu_arlen     = 4'(BLK_WORDS - 1);
    assign bus_io.ifu_rready    = (state_q == StR);
    assign bus_io.icache_araddr = fetch_pc_q[ICACHE_AW-1:0];
    assign bus_io.icache_awaddr = araddr_q[ICACHE_AW-1:0] + ICACHE_AW'({beat_q, 2'b00});
    assign bus_io.icache_wdata  = bus_io.ifu_rdata;
    assign bus_io.icache_wvalid = wvalid;
    assign bus_io.idu_valid     = (count_q != '0);
    assign bus_io.idu_inst      = mem_inst_q[rd_ptr_q];
    assign bus_io.idu_pc        = mem_pc_q[rd_ptr_q];
    assign bus_io.idu_err       = mem_err_q[rd_ptr_q];
endmodule

// File: tb/tb_ysyx_23060236_ifu_pf.sv
// Directed bench for the prefetch unit: cold miss, back-pressure, redirect
// during a burst, bus error with halt, flush against push/pop, async reset.
module tb_ysyx_23060236_ifu_pf;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    ysyx_23060236_ifu_pf_if #(.ICACHE_AW(25)) bus ();

    ysyx_23060236_ifu_pf #(
        .ENTRY_ADDR (32'h3000_0000),
        .BLK_WORDS  (8),
        .FIFO_DEPTH (4),
        .ICACHE_AW  (25)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_arvalid(input string tag);
        int n = 0;
        while (bus.ifu_arvalid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(bus.ifu_arvalid), 32'd1);
    endtask

    task automatic wait_idu(input string tag);
        int n = 0;
        while (bus.idu_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(bus.idu_valid), 32'd1);
    endtask

    // Drive one 8-beat burst; err_beat/redir_beat select beats (-1 for none)
    task automatic burst(input string tag, input logic [31:0] line, input logic [31:0] dbase,
                         input int err_beat, input int redir_beat,
                         input logic [31:0] redir_addr, input int exp_writes);
        int writes = 0;
        logic [31:0] a;
        for (int i = 0; i < 8; i++) begin
            bus.ifu_rvalid     = 1'b1;
            bus.ifu_rdata      = dbase + 32'(i);
            bus.ifu_rresp      = (i == err_beat) ? 2'b10 : 2'b00;
            bus.ifu_rlast      = (i == 7);
            bus.redirect_valid = (i == redir_beat);
            bus.redirect_addr  = redir_addr;
            #1;
            chk({tag, "_rready"}, 32'(bus.ifu_rready), 32'd1);
            if (bus.icache_wvalid === 1'b1) writes++;
            if (i == err_beat) begin
                chk({tag, "_wvalid_bad"}, 32'(bus.icache_wvalid), 32'd0);
            end else begin
                a = (line + 32'(4 * i)) & 32'h01FF_FFFF;
                chk({tag, "_wvalid"}, 32'(bus.icache_wvalid), 32'd1);
                chk({tag, "_awaddr"}, 32'(bus.icache_awaddr), a);
                chk({tag, "_wdata"}, bus.icache_wdata, dbase + 32'(i));
            end
            step();
        end
        bus.ifu_rvalid     = 1'b0;
        bus.ifu_rlast      = 1'b0;
        bus.ifu_rresp      = 2'b00;
        bus.redirect_valid = 1'b0;
        chk({tag, "_writes"}, 32'(writes), 32'(exp_writes));
    endtask

    task automatic ar_handshake();
        bus.ifu_arready = 1'b1;
        step();
        bus.ifu_arready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        bus.ifu_arready    = 1'b0;
        bus.ifu_rdata      = 32'h0;
        bus.ifu_rresp      = 2'b00;
        bus.ifu_rvalid     = 1'b0;
        bus.ifu_rlast      = 1'b0;
        bus.icache_rdata   = 32'h0;
        bus.icache_hit     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 32'h0;
        bus.idu_ready      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_arvalid", 32'(bus.ifu_arvalid), 32'd0);
        chk("rst_rready", 32'(bus.ifu_rready), 32'd0);
        chk("rst_wvalid", 32'(bus.icache_wvalid), 32'd0);
        chk("rst_idu_valid", 32'(bus.idu_valid), 32'd0);
        chk("rst_araddr", bus.ifu_araddr, 32'h3000_0000);
        chk("rst_icache_araddr", 32'(bus.icache_araddr), 32'h0);
        chk("rst_arlen", 32'(bus.ifu_arlen), 32'd7);
        chk("rst_arburst", 32'(bus.ifu_arburst), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss, refill, then hit
        wait_arvalid("cold_arvalid");
        chk("cold_araddr", bus.ifu_araddr, 32'h3000_0000);
        ar_handshake();
        burst("cold", 32'h3000_0000, 32'hA000_0000, -1, -1, 32'h0, 8);
        bus.icache_hit   = 1'b1;
        bus.icache_rdata = 32'hA000_0000;
        wait_idu("cold_idu_valid");
        chk("cold_idu_pc", bus.idu_pc, 32'h3000_0000);
        chk("cold_idu_inst", bus.idu_inst, 32'hA000_0000);
        chk("cold_idu_err", 32'(bus.idu_err), 32'd0);

        // Back-pressure: queue fills to 4, fetch_pc stops at +0x10
        bus.icache_rdata = 32'h0000_0013;
        do_reset();
        repeat (12) step();
        chk("bp_idu_valid", 32'(bus.idu_valid), 32'd1);
        chk("bp_fetch_pc", 32'(bus.icache_araddr), 32'h10);
        repeat (6) step();
        chk("bp_fetch_pc_hold", 32'(bus.icache_araddr), 32'h10);
        chk("bp_no_ar", 32'(bus.ifu_arvalid), 32'd0);
        bus.idu_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_pop_pc", bus.idu_pc, 32'h3000_0000 + 32'(4 * k));
            chk("bp_pop_inst", bus.idu_inst, 32'h0000_0013);
            step();
        end
        bus.idu_ready = 1'b0;

        // Redirect on beat 3: all beats written, no push, next line refetched
        bus.icache_hit = 1'b0;
        do_reset();
        wait_arvalid("rd_arvalid");
        chk("rd_araddr0", bus.ifu_araddr, 32'h3000_0000);
        ar_handshake();
        burst("rd", 32'h3000_0000, 32'hB000_0000, -1, 3, 32'h3000_0100, 8);
        chk("rd_no_push", 32'(bus.idu_valid), 32'd0);
        wait_arvalid("rd_arvalid2");
        chk("rd_araddr1", bus.ifu_araddr, 32'h3000_0100);
        chk("rd_no_push2", 32'(bus.idu_valid), 32'd0);

        // Bus error on beat 3: 7 writes, error entry, halt until redirect
        do_reset();
        wait_arvalid("be_arvalid");
        ar_handshake();
        burst("be", 32'h3000_0000, 32'hC000_0000, 3, -1, 32'h0, 7);
        chk("be_idu_valid", 32'(bus.idu_valid), 32'd1);
        chk("be_idu_err", 32'(bus.idu_err), 32'd1);
        chk("be_idu_inst", bus.idu_inst, 32'h0);
        chk("be_idu_pc", bus.idu_pc, 32'h3000_0000);
        repeat (6) step();
        chk("be_halt_no_ar", 32'(bus.ifu_arvalid), 32'd0);
        bus.idu_ready = 1'b1;
        step();
        bus.idu_ready = 1'b0;
        chk("be_popped", 32'(bus.idu_valid), 32'd0);
        repeat (4) step();
        chk("be_halt_no_ar2", 32'(bus.ifu_arvalid), 32'd0);
        chk("be_halt_no_push", 32'(bus.idu_valid), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h3000_0043;
        step();
        bus.redirect_valid = 1'b0;
        wait_arvalid("be_resume");
        chk("be_resume_araddr", bus.ifu_araddr, 32'h3000_0040);
        chk("be_resume_pc", 32'(bus.icache_araddr), 32'h40);

        // Redirect coincident with push and pop
        bus.icache_hit   = 1'b1;
        bus.icache_rdata = 32'h0000_0013;
        do_reset();
        step();
        step();
        chk("rp_pre", 32'(bus.idu_valid), 32'd1);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h3000_0200;
        bus.idu_ready      = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        bus.idu_ready      = 1'b0;
        chk("rp_flush", 32'(bus.idu_valid), 32'd0);
        wait_idu("rp_refill");
        chk("rp_pc", bus.idu_pc, 32'h3000_0200);

        // Asynchronous reset in the middle of a burst
        do_reset();
        step();
        step();
        bus.icache_hit = 1'b0;
        step();
        step();
        chk("ar_arvalid", 32'(bus.ifu_arvalid), 32'd1);
        ar_handshake();
        bus.ifu_rvalid = 1'b1;
        bus.ifu_rdata  = 32'hD000_0000;
        bus.ifu_rresp  = 2'b00;
        bus.ifu_rlast  = 1'b0;
        #1;
        chk("ar_rready_pre", 32'(bus.ifu_rready), 32'd1);
        chk("ar_wvalid_pre", 32'(bus.icache_wvalid), 32'd1);
        chk("ar_idu_pre", 32'(bus.idu_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_rready", 32'(bus.ifu_rready), 32'd0);
        chk("ar_wvalid", 32'(bus.icache_wvalid), 32'd0);
        chk("ar_idu_valid", 32'(bus.idu_valid), 32'd0);
        chk("ar_arvalid_rst", 32'(bus.ifu_arvalid), 32'd0);
        bus.ifu_rvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
